// File: rtl/rob_commit_if.sv
// ROB dequeue handshake between the ROB FIFO head (master) and the commit stage (slave).
// rob_deq_valid  : head entry present
// rob_deq_data   : {complete, exc, has_dest, dest, result, pc}, MSB->LSB
// rob_deq_addr   : ROB id of the head entry
// rob_deq_ready  : commit stage pops the head this cycle (combinational)
interface rob_commit_if #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned ARF_ADDR_W    = 5,
    parameter int unsigned ROB_PTR_WIDTH = 3
);
    localparam int unsigned ENTRY_WIDTH = 3 + ARF_ADDR_W + 2 * XLEN;

    logic                     rob_deq_valid;
    logic [ENTRY_WIDTH-1:0]   rob_deq_data;
    logic [ROB_PTR_WIDTH-1:0] rob_deq_addr;
    logic                     rob_deq_ready;

    modport master (
        output rob_deq_valid,
        output rob_deq_data,
        output rob_deq_addr,
        input  rob_deq_ready
    );

    modport slave (
        input  rob_deq_valid,
        input  rob_deq_data,
        input  rob_deq_addr,
        output rob_deq_ready
    );
endinterface

// File: rtl/rob_commit.sv
// In-order retirement stage below the ROB dequeue port. Pops a complete head,
// writes its result to the ARF and counts it; an excepting head raises a
// one-cycle flush to TRAP_VEC and blocks retirement for FLUSH_CYCLES cycles.
// Ports:
//   clk, rst_sH        : clock, synchronous active-high reset
//   rob_deq            : ROB head handshake (slave side, ready is combinational)
//   arf_we/waddr/wdata : registered ARF write port (x0 writes suppressed)
//   retire_valid/rob_id: registered retire pulse and retired ROB id
//   flush/epc/target   : registered one-cycle flush pulse, faulting PC, redirect PC
//   retired_count      : registered retired-instruction counter (wraps)
module rob_commit #(
    parameter int unsigned    XLEN          = 32,
    parameter int unsigned    ARF_ADDR_W    = 5,
    parameter int unsigned    ROB_PTR_WIDTH = 3,
    parameter int unsigned    FLUSH_CYCLES  = 4,
    parameter logic [XLEN-1:0] TRAP_VEC     = XLEN'(32'h0000_0100)
) (
    input  logic                     clk,
    input  logic                     rst_sH,
    rob_commit_if.slave              rob_deq,
    output logic                     arf_we,
    output logic [ARF_ADDR_W-1:0]    arf_waddr,
    output logic [XLEN-1:0]          arf_wdata,
    output logic                     retire_valid,
    output logic [ROB_PTR_WIDTH-1:0] retire_rob_id,
    output logic                     flush,
    output logic [XLEN-1:0]          flush_epc,
    output logic [XLEN-1:0]          flush_target,
    output logic [31:0]              retired_count
);
    localparam int unsigned ENTRY_WIDTH = 3 + ARF_ADDR_W + 2 * XLEN;
    localparam int unsigned RES_LSB     = XLEN;
    localparam int unsigned DEST_LSB    = 2 * XLEN;
    localparam int unsigned HD_BIT      = 2 * XLEN + ARF_ADDR_W;
    localparam int unsigned EXC_BIT     = HD_BIT + 1;
    localparam int unsigned CMP_BIT     = HD_BIT + 2;
    localparam int unsigned CNT_W       = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t                   state_q;
    logic [CNT_W-1:0]         drain_q;
    logic                     arf_we_q;
    logic [ARF_ADDR_W-1:0]    arf_waddr_q;
    logic [XLEN-1:0]          arf_wdata_q;
    logic                     retire_valid_q;
    logic [ROB_PTR_WIDTH-1:0] retire_rob_id_q;
    logic                     flush_q;
    logic [XLEN-1:0]          flush_epc_q;
    logic [XLEN-1:0]          flush_target_q;
    logic [31:0]              retired_count_q;

    // Head entry field decode
    logic [ENTRY_WIDTH-1:0]   ent_c;
    logic                     complete_c;
    logic                     exc_c;
    logic                     has_dest_c;
    logic [ARF_ADDR_W-1:0]    dest_c;
    logic [XLEN-1:0]          result_c;
    logic [XLEN-1:0]          pc_c;
    logic                     pop_c;

    assign ent_c      = rob_deq.rob_deq_data;
    assign complete_c = ent_c[CMP_BIT];
    assign exc_c      = ent_c[EXC_BIT];
    assign has_dest_c = ent_c[HD_BIT];
    assign dest_c     = ent_c[DEST_LSB +: ARF_ADDR_W];
    assign result_c   = ent_c[RES_LSB +: XLEN];
    assign pc_c       = ent_c[0 +: XLEN];

    // Pop only a complete head while not draining after a flush
    assign pop_c                 = (state_q == ST_RUN) && rob_deq.rob_deq_valid && complete_c;
    assign rob_deq.rob_deq_ready = pop_c;

    // Retire/flush FSM with registered outputs; pulses default low every cycle
    always_ff @(posedge clk) begin
        if (rst_sH) begin
            state_q         <= ST_RUN;
            drain_q         <= '0;
            arf_we_q        <= 1'b0;
            arf_waddr_q     <= '0;
            arf_wdata_q     <= '0;
            retire_valid_q  <= 1'b0;
            retire_rob_id_q <= '0;
            flush_q         <= 1'b0;
            flush_epc_q     <= '0;
            flush_target_q  <= '0;
            retired_count_q <= '0;
        end else begin
            arf_we_q       <= 1'b0;
            retire_valid_q <= 1'b0;
            flush_q        <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (pop_c) begin
                        if (exc_c) begin
                            // Excepting head is consumed but neither written nor counted
                            flush_q        <= 1'b1;
                            flush_epc_q    <= pc_c;
                            flush_target_q <= TRAP_VEC;
                            state_q        <= ST_FLUSH;
                            drain_q        <= CNT_W'(FLUSH_CYCLES);
                        end else begin
                            retire_valid_q  <= 1'b1;
                            retire_rob_id_q <= rob_deq.rob_deq_addr;
                            arf_we_q        <= has_dest_c && (dest_c != '0);
                            arf_waddr_q     <= dest_c;
                            arf_wdata_q     <= result_c;
                            retired_count_q <= retired_count_q + 32'd1;
                        end
                    end
                end
                ST_FLUSH: begin
                    // Counter value 1 marks the last blocked cycle
                    if (drain_q == CNT_W'(1)) begin
                        state_q <= ST_RUN;
                        drain_q <= '0;
                    end else begin
                        drain_q <= drain_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                    drain_q <= '0;
                end
            endcase
        end
    end

    assign arf_we        = arf_we_q;
    assign arf_waddr     = arf_waddr_q;
    assign arf_wdata     = arf_wdata_q;
    assign retire_valid  = retire_valid_q;
    assign retire_rob_id = retire_rob_id_q;
    assign flush         = flush_q;
    assign flush_epc     = flush_epc_q;
    assign flush_target  = flush_target_q;
    assign retired_count = retired_count_q;
endmodule

// File: tb/tb_rob_commit.sv
// Scoreboard bench for rob_commit: stimulus pushes expected retire/flush events,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_rob_commit;
    logic        clk;
    logic        rst_sH;
    logic        arf_we;
    logic [4:0]  arf_waddr;
    logic [31:0] arf_wdata;
    logic        retire_valid;
    logic [2:0]  retire_rob_id;
    logic        flush;
    logic [31:0] flush_epc;
    logic [31:0] flush_target;
    logic [31:0] retired_count;

    rob_commit_if rif ();

    rob_commit dut (
        .clk           (clk),
        .rst_sH        (rst_sH),
        .rob_deq       (rif.slave),
        .arf_we        (arf_we),
        .arf_waddr     (arf_waddr),
        .arf_wdata     (arf_wdata),
        .retire_valid  (retire_valid),
        .retire_rob_id (retire_rob_id),
        .flush         (flush),
        .flush_epc     (flush_epc),
        .flush_target  (flush_target),
        .retired_count (retired_count)
    );

    typedef struct {
        logic        is_flush;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [2:0]  id;
        logic [31:0] cnt;
        logic [31:0] epc;
        int          edge_n;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [31:0] model_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every output pulse must match the oldest expected event on its edge
    always @(negedge clk) begin
        exp_t e;
        if (!rst_sH) begin
            if (sb.size() > 0 && sb[0].edge_n < cyc) begin
                total++;
                bad++;
                $display("FAIL missing_event exp_edge=%0d now=%0d", sb[0].edge_n, cyc);
                void'(sb.pop_front());
            end
            if (retire_valid || arf_we || flush) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_event rv=%b we=%b flush=%b cyc=%0d",
                             retire_valid, arf_we, flush, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("event_edge", 32'(cyc), 32'(e.edge_n));
                    if (e.is_flush) begin
                        chk("flush", 32'(flush), 32'd1);
                        chk("flush_rv", 32'(retire_valid), 32'd0);
                        chk("flush_we", 32'(arf_we), 32'd0);
                        chk("flush_epc", flush_epc, e.epc);
                        chk("flush_target", flush_target, 32'h0000_0100);
                        chk("flush_count", retired_count, e.cnt);
                    end else begin
                        chk("retire_valid", 32'(retire_valid), 32'd1);
                        chk("retire_flush", 32'(flush), 32'd0);
                        chk("arf_we", 32'(arf_we), 32'(e.we));
                        chk("retire_rob_id", 32'(retire_rob_id), 32'(e.id));
                        chk("retired_count", retired_count, e.cnt);
                        if (e.we) begin
                            chk("arf_waddr", 32'(arf_waddr), 32'(e.waddr));
                            chk("arf_wdata", arf_wdata, e.wdata);
                        end
                    end
                end
            end
        end
    end

    // One cycle of stimulus starting at a negedge; ends at the next negedge
    task automatic step(input logic v, input logic c, input logic x, input logic hd,
                        input logic [4:0] d, input logic [31:0] r, input logic [31:0] pc,
                        input logic [2:0] id, input logic exp_rdy);
        exp_t e;
        rif.rob_deq_valid = v;
        rif.rob_deq_data  = {c, x, hd, d, r, pc};
        rif.rob_deq_addr  = id;
        #1;
        chk("rob_deq_ready", 32'(rif.rob_deq_ready), 32'(exp_rdy));
        if (exp_rdy) begin
            e.is_flush = x;
            e.we       = hd && (d != 5'd0);
            e.waddr    = d;
            e.wdata    = r;
            e.id       = id;
            e.epc      = pc;
            e.edge_n   = cyc + 1;
            if (!x) model_cnt = model_cnt + 32'd1;
            e.cnt      = model_cnt;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 3'd0, 1'b0);
    endtask

    // Reset for one edge starting at a negedge, then verify the cleared outputs
    task automatic do_reset();
        rst_sH            = 1'b1;
        rif.rob_deq_valid = 1'b0;
        @(negedge clk);
        rst_sH    = 1'b0;
        model_cnt = 32'd0;
        #1;
        chk("rst_arf_we", 32'(arf_we), 32'd0);
        chk("rst_retire_valid", 32'(retire_valid), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_count", retired_count, 32'd0);
        chk("rst_waddr", 32'(arf_waddr), 32'd0);
        chk("rst_wdata", arf_wdata, 32'd0);
        chk("rst_rob_id", 32'(retire_rob_id), 32'd0);
        chk("rst_epc", flush_epc, 32'd0);
        chk("rst_target", flush_target, 32'd0);
    endtask

    initial begin
        rst_sH            = 1'b1;
        rif.rob_deq_valid = 1'b0;
        rif.rob_deq_data  = '0;
        rif.rob_deq_addr  = '0;
        @(negedge clk);
        do_reset();

        // Basic retire: dest=5, 0xDEADBEEF, id 2
        step(1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 32'h10, 3'd2, 1'b1);
        idle();

        // Incomplete head is held for 3 cycles, then pops when complete
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 32'h1234_5678, 32'h14, 3'd3, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 32'h1234_5678, 32'h14, 3'd3, 1'b1);

        // x0 destination retires without an ARF write
        step(1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 32'hCAFE_0000, 32'h18, 3'd4, 1'b1);
        idle();

        // Exception at pc 0x40: flush, then 4 blocked cycles with a ready head
        step(1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 32'h0, 32'h40, 3'd5, 1'b1);
        repeat (4) step(1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 32'h9999_0001, 32'h100, 3'd6, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 32'h9999_0001, 32'h100, 3'd6, 1'b1);
        idle();

        // 8 back-to-back retires from a fresh reset
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'(i % 2), 5'(i + 1), 32'hA000_0000 + 32'(i),
                 32'h200 + 32'(4 * i), 3'(i), 1'b1);
        end
        chk("count_after_8", retired_count, 32'd8);
        idle();

        // Counter wrap: preload all-ones, retire one
        force dut.retired_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_count_q;
        model_cnt = 32'hFFFF_FFFF;
        step(1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 32'h0BAD_F00D, 32'h300, 3'd1, 1'b1);
        chk("count_wrap", retired_count, 32'd0);
        idle();

        // Reset two cycles into a drain window
        step(1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 32'h80, 3'd2, 1'b1);
        repeat (2) step(1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 32'h5555_AAAA, 32'h84, 3'd3, 1'b0);
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 32'h5555_AAAA, 32'h84, 3'd3, 1'b1);
        repeat (3) idle();

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
